// File: rtl/rotor_pwm_scheduler.sv
// Servo PWM generator for the braille rotor array: per-rotor shadow/active angles, frame-aligned updates.
// Outputs registered one cycle behind the counters; cmd_ready stays high after reset (no backpressure).
module rotor_pwm_scheduler #(
   parameter int NUM_ROTORS    = 32,
   parameter int IDX_W         = 5,
   parameter int TICK_DIV      = 50,
   parameter int FRAME_TICKS   = 20000,
   parameter int MIN_TICKS     = 500,
   parameter int STEP_TICKS    = 11,
   parameter int MAX_ANGLE     = 180,
   parameter int NEUTRAL_ANGLE = 90
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [IDX_W-1:0]      cmd_rotor,
   input  logic [7:0]            cmd_angle,
   output logic [NUM_ROTORS-1:0] pwm_out,
   output logic                  frame_start,
   output logic                  err_idx,
   output logic                  clamped
);

   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [TW-1:0]         r_tick_cnt;
   logic [15:0]           r_frame_cnt;
   logic [7:0]            r_shadow [NUM_ROTORS];
   logic [7:0]            r_active [NUM_ROTORS];
   logic [NUM_ROTORS-1:0] r_pwm;
   logic                  r_cmd_ready;
   logic                  r_frame_start;
   logic                  r_err_idx;
   logic                  r_clamped;

   logic                  w_tick;
   logic                  w_boundary;
   logic                  w_accept;
   logic                  w_idx_ok;
   logic                  w_over;
   logic [7:0]            w_angle;
   logic [15:0]           w_pulse [NUM_ROTORS];

   assign w_tick     = (r_tick_cnt == TW'(TICK_DIV - 1));
   assign w_boundary = w_tick && (r_frame_cnt == 16'(FRAME_TICKS - 1));
   assign w_accept   = cmd_valid && r_cmd_ready;
   assign w_idx_ok   = (int'(cmd_rotor) < NUM_ROTORS);
   assign w_over     = (cmd_angle > 8'(MAX_ANGLE));
   assign w_angle    = w_over ? 8'(MAX_ANGLE) : cmd_angle;

   always_comb begin
      for (int i = 0; i < NUM_ROTORS; i++) begin
         w_pulse[i] = 16'(MIN_TICKS) + 16'(r_active[i]) * 16'(STEP_TICKS);
      end
   end

   // Prescaler and frame counter; the frame restarts from 0 at reset release.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_tick_cnt    <= '0;
         r_frame_cnt   <= '0;
         r_frame_start <= 1'b0;
      end else begin
         r_frame_start <= w_boundary;
         if (w_tick) begin
            r_tick_cnt  <= '0;
            r_frame_cnt <= w_boundary ? 16'd0 : r_frame_cnt + 16'd1;
         end else begin
            r_tick_cnt  <= r_tick_cnt + TW'(1);
         end
      end
   end

   // The boundary copy reads the pre-write shadow, so a same-cycle write lands one frame later.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_ROTORS; i++) begin
            r_shadow[i] <= 8'(NEUTRAL_ANGLE);
            r_active[i] <= 8'(NEUTRAL_ANGLE);
         end
      end else begin
         for (int i = 0; i < NUM_ROTORS; i++) begin
            if (w_accept && w_idx_ok && (cmd_rotor == IDX_W'(i))) begin
               r_shadow[i] <= w_angle;
            end
            if (w_boundary) begin
               r_active[i] <= r_shadow[i];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pwm       <= '0;
         r_cmd_ready <= 1'b0;
         r_err_idx   <= 1'b0;
         r_clamped   <= 1'b0;
      end else begin
         r_cmd_ready <= 1'b1;
         r_err_idx   <= w_accept && !w_idx_ok;
         r_clamped   <= w_accept && w_idx_ok && w_over;
         for (int i = 0; i < NUM_ROTORS; i++) begin
            r_pwm[i] <= (r_frame_cnt < w_pulse[i]);
         end
      end
   end

   assign pwm_out     = r_pwm;
   assign cmd_ready   = r_cmd_ready;
   assign frame_start = r_frame_start;
   assign err_idx     = r_err_idx;
   assign clamped     = r_clamped;

endmodule

// File: tb/tb_rotor_pwm_scheduler.sv
// Directed bench for rotor_pwm_scheduler: per-frame expected widths/pulse counts queued, then measured.
module tb_rotor_pwm_scheduler;

   localparam int N      = 4;
   localparam int FRAME  = 800;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] cmd_rotor;
   logic [7:0] cmd_angle;
   logic [3:0] pwm_out;
   logic       frame_start;
   logic       err_idx;
   logic       clamped;

   int total = 0;
   int bad   = 0;
   int q_w[$];
   int q_err[$];
   int q_clp[$];

   always #5 clk = ~clk;

   rotor_pwm_scheduler #(
      .NUM_ROTORS(4), .IDX_W(3), .TICK_DIV(2), .FRAME_TICKS(400),
      .MIN_TICKS(10), .STEP_TICKS(1), .MAX_ANGLE(180), .NEUTRAL_ANGLE(90)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_rotor(cmd_rotor), .cmd_angle(cmd_angle),
      .pwm_out(pwm_out), .frame_start(frame_start),
      .err_idx(err_idx), .clamped(clamped)
   );

   task automatic check(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input int w0, input int w1, input int w2, input int w3,
                           input int e, input int c);
      q_w.push_back(w0); q_w.push_back(w1); q_w.push_back(w2); q_w.push_back(w3);
      q_err.push_back(e);
      q_clp.push_back(c);
   endtask

   task automatic pop_widths(input string tag, input int hi0, input int hi1,
                             input int hi2, input int hi3);
      int hi[4];
      hi[0] = hi0; hi[1] = hi1; hi[2] = hi2; hi[3] = hi3;
      for (int r = 0; r < N; r++) begin
         if (q_w.size() == 0) check($sformatf("%s_q_empty", tag), 0, 1);
         else check($sformatf("%s_w%0d", tag, r), hi[r], q_w.pop_front());
      end
   endtask

   // Runs from reset release to the first frame_start; first frame has no frame_start of its own.
   task automatic first_frame(input string tag);
      int n = 0;
      int hi[4];
      for (int r = 0; r < N; r++) hi[r] = 0;
      while (n < 2000) begin
         @(negedge clk);
         n++;
         for (int r = 0; r < N; r++) hi[r] += (pwm_out[r] === 1'b1) ? 1 : 0;
         if (frame_start === 1'b1) break;
      end
      check({tag, "_len"}, n, FRAME);
      check({tag, "_rdy"}, (cmd_ready === 1'b1) ? 1 : 0, 1);
      pop_widths(tag, hi[0], hi[1], hi[2], hi[3]);
      void'(q_err.pop_front());
      void'(q_clp.pop_front());
   endtask

   // Entered on a frame_start cycle; leaves on the next frame_start cycle.
   task automatic measure(input string tag,
                          input int at1, input logic [2:0] r1, input logic [7:0] a1,
                          input int at2, input logic [2:0] r2, input logic [7:0] a2);
      int hi[4];
      int e = 0;
      int c = 0;
      int extra_fs = 0;
      for (int r = 0; r < N; r++) hi[r] = 0;
      for (int k = 0; k < FRAME; k++) begin
         for (int r = 0; r < N; r++) hi[r] += (pwm_out[r] === 1'b1) ? 1 : 0;
         e += (err_idx === 1'b1) ? 1 : 0;
         c += (clamped === 1'b1) ? 1 : 0;
         if (k > 0 && frame_start !== 1'b0) extra_fs++;
         if (k == at1) begin
            cmd_valid = 1'b1; cmd_rotor = r1; cmd_angle = a1;
         end else if (k == at2) begin
            cmd_valid = 1'b1; cmd_rotor = r2; cmd_angle = a2;
         end else begin
            cmd_valid = 1'b0;
         end
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      check({tag, "_period"}, (frame_start === 1'b1) ? 1 : 0, 1);
      check({tag, "_stray_fs"}, extra_fs, 0);
      pop_widths(tag, hi[0], hi[1], hi[2], hi[3]);
      check({tag, "_err"}, e, q_err.pop_front());
      check({tag, "_clp"}, c, q_clp.pop_front());
   endtask

   initial begin
      reset_n   = 1'b0;
      cmd_valid = 1'b0;
      cmd_rotor = '0;
      cmd_angle = '0;
      repeat (3) @(negedge clk);
      check("rst_pwm", int'(pwm_out), 0);
      check("rst_rdy", (cmd_ready === 1'b0) ? 1 : 0, 1);
      check("rst_fs", (frame_start === 1'b0) ? 1 : 0, 1);
      check("rst_err", (err_idx === 1'b0) ? 1 : 0, 1);
      check("rst_clp", (clamped === 1'b0) ? 1 : 0, 1);

      reset_n = 1'b1;
      push_exp(200, 200, 200, 200, 0, 0);
      first_frame("rel1");

      push_exp(200, 200, 200, 200, 0, 0);
      measure("idle", -1, 3'd0, 8'd0, -1, 3'd0, 8'd0);
      push_exp(200, 200, 200, 200, 0, 0);
      measure("wr2", 100, 3'd2, 8'd0, -1, 3'd0, 8'd0);
      push_exp(200, 200, 20, 200, 0, 1);
      measure("clamp1", 300, 3'd1, 8'd250, -1, 3'd0, 8'd0);
      push_exp(200, 380, 20, 200, 1, 0);
      measure("badidx", 150, 3'd5, 8'd30, -1, 3'd0, 8'd0);
      push_exp(200, 380, 20, 200, 0, 0);
      measure("bndry_k", 799, 3'd0, 8'd20, -1, 3'd0, 8'd0);
      push_exp(200, 380, 20, 200, 0, 0);
      measure("bndry_k1", -1, 3'd0, 8'd0, -1, 3'd0, 8'd0);
      push_exp(60, 380, 20, 200, 0, 0);
      measure("bndry_k2", 100, 3'd3, 8'd10, 101, 3'd3, 8'd40);
      push_exp(60, 380, 20, 100, 0, 0);
      measure("lastwins", -1, 3'd0, 8'd0, -1, 3'd0, 8'd0);

      for (int k = 0; k < 50; k++) begin
         cmd_valid = (k == 0);
         cmd_rotor = 3'd0;
         cmd_angle = 8'd180;
         @(negedge clk);
      end
      check("pre_rst_pwm", int'(pwm_out), 4'b1011);
      #2 reset_n = 1'b0;
      #1;
      check("async_rst_pwm", int'(pwm_out), 0);
      check("async_rst_rdy", (cmd_ready === 1'b0) ? 1 : 0, 1);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      push_exp(200, 200, 200, 200, 0, 0);
      first_frame("rel2");
      push_exp(200, 200, 200, 200, 0, 0);
      measure("after_rst", -1, 3'd0, 8'd0, -1, 3'd0, 8'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
